// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP slave.
package jtag_pkg;

    localparam int unsigned IR_CODE_W = 4;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    localparam logic [IR_CODE_W-1:0] IR_IDCODE  = 4'b0001;
    localparam logic [IR_CODE_W-1:0] IR_USER    = 4'b1000;
    localparam logic [IR_CODE_W-1:0] IR_BYPASS  = 4'b1111;
    localparam logic [IR_CODE_W-1:0] IR_CAPTURE = 4'b0001;

    // Unknown instruction codes fall back to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [IR_CODE_W-1:0] ir);
        case (ir)
            IR_IDCODE: decode_ir = DR_IDCODE;
            IR_USER:   decode_ir = DR_USER;
            default:   decode_ir = DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with registered one-hot state strobes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       tlr
);

    tap_state_e state_q, state_d;
    logic [6:0] strobe_q, strobe_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Strobes are decoded from the next state so their flops track state_q exactly.
    always_comb begin
        strobe_d = {(state_d == CAP_DR),   (state_d == SHIFT_DR), (state_d == UPD_DR),
                    (state_d == CAP_IR),   (state_d == SHIFT_IR), (state_d == UPD_IR),
                    (state_d == TLR)};
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q  <= TLR;
            strobe_q <= 7'b000_0001;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
        end
    end

    assign state      = state_q;
    assign capture_dr = strobe_q[6];
    assign shift_dr   = strobe_q[5];
    assign update_dr  = strobe_q[4];
    assign capture_ir = strobe_q[3];
    assign shift_ir   = strobe_q[2];
    assign update_ir  = strobe_q[1];
    assign tlr        = strobe_q[0];

endmodule

// File: rtl/jtag_tap_modport.sv
// JTAG TAP slave: instruction register plus BYPASS, IDCODE and USER data registers.
module jtag_tap_modport
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1A2B_3C4D,
    parameter int unsigned USER_W     = 8
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic [USER_W-1:0] user_q
);

    tap_state_e state;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tlr;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .state      (state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tlr        (tlr)
    );

    logic [IR_W-1:0]   ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [31:0]       id_sr_q, id_sr_d;
    logic [USER_W-1:0] user_sr_q, user_sr_d, user_reg_q, user_reg_d;
    logic              bypass_q, bypass_d;
    logic              tdo_q, tdo_d;
    dr_sel_e           dr_sel;

    assign dr_sel = decode_ir(IR_CODE_W'(ir_q));

    always_comb begin
        ir_d       = ir_q;
        ir_sr_d    = ir_sr_q;
        id_sr_d    = id_sr_q;
        user_sr_d  = user_sr_q;
        user_reg_d = user_reg_q;
        bypass_d   = bypass_q;

        if (capture_ir) ir_sr_d = IR_W'(IR_CAPTURE);
        if (shift_ir)   ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
        if (update_ir)  ir_d    = ir_sr_q;
        // Entering (or holding) TLR through tms reloads IDCODE; user data survives.
        if ((tlr || state == SEL_IR) && tms) ir_d = IR_W'(IR_IDCODE);

        if (capture_dr) begin
            case (dr_sel)
                DR_IDCODE: id_sr_d   = IDCODE_VAL;
                DR_USER:   user_sr_d = user_reg_q;
                default:   bypass_d  = 1'b0;
            endcase
        end
        if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE: id_sr_d   = {tdi, id_sr_q[31:1]};
                DR_USER:   user_sr_d = {tdi, user_sr_q[USER_W-1:1]};
                default:   bypass_d  = tdi;
            endcase
        end
        if (update_dr && dr_sel == DR_USER) user_reg_d = user_sr_q;
    end

    always_comb begin
        tdo_d = 1'b0;
        if (shift_ir) begin
            tdo_d = ir_sr_q[0];
        end else if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE: tdo_d = id_sr_q[0];
                DR_USER:   tdo_d = user_sr_q[0];
                default:   tdo_d = bypass_q;
            endcase
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_q       <= IR_W'(IR_IDCODE);
            ir_sr_q    <= '0;
            id_sr_q    <= '0;
            user_sr_q  <= '0;
            user_reg_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_sr_q    <= ir_sr_d;
            id_sr_q    <= id_sr_d;
            user_sr_q  <= user_sr_d;
            user_reg_q <= user_reg_d;
            bypass_q   <= bypass_d;
        end
    end

    // tdo launches on the falling edge so the master samples it half a cycle later.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) tdo_q <= 1'b0;
        else       tdo_q <= tdo_d;
    end

    assign tdo    = tdo_q;
    assign user_q = user_reg_q;

endmodule

// File: tb/tb_jtag_tap_modport.sv
// Directed bench for the JTAG TAP slave, acting as the JTAG master.
module tb_jtag_tap_modport;
    import jtag_pkg::*;

    logic       tck = 1'b0;
    logic       trst = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [7:0] user_q;

    int checks = 0;
    int failures = 0;

    jtag_tap_modport dut (
        .tck    (tck),
        .trst   (trst),
        .tms    (tms),
        .tdi    (tdi),
        .tdo    (tdo),
        .user_q (user_q)
    );

    always #10 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One tck cycle: drive tms/tdi after the falling edge, sample tdo at the rising edge.
    task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_s);
        @(negedge tck);
        #3;
        tms = tms_v;
        tdi = tdi_v;
        @(posedge tck);
        tdo_s = tdo;
        #1;
    endtask

    task automatic walk(input logic tms_v);
        logic unused;
        step(tms_v, 1'b0, unused);
    endtask

    // Shift n bits LSB-first from SHIFT_x, leaving via EXIT1 on the last bit.
    task automatic scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic o;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], o);
            dout[i] = o;
        end
    endtask

    // From RTI: IR scan of a 4-bit code, returning to RTI.
    task automatic ir_scan(input logic [3:0] code, output logic [31:0] dout);
        walk(1'b1); walk(1'b1); walk(1'b0); walk(1'b0);
        scan(4, 32'(code), dout);
        walk(1'b1); walk(1'b0);
    endtask

    // From RTI: DR scan of n bits, returning to RTI.
    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        walk(1'b1); walk(1'b0); walk(1'b0);
        scan(n, din, dout);
        walk(1'b1); walk(1'b0);
    endtask

    initial begin
        logic [31:0] d;

        #15;
        chk("reset_state", 32'(dut.u_fsm.state_q), 32'(TLR));
        chk("reset_ir", 32'(dut.ir_q), 32'h1);
        chk("reset_tdo", 32'(tdo), 32'h0);
        chk("reset_user", 32'(user_q), 32'h0);
        @(negedge tck);
        trst = 1'b1;

        // IDCODE read straight out of reset
        walk(1'b0); walk(1'b1); walk(1'b0); walk(1'b0);
        chk("enter_shift_dr", 32'(dut.u_fsm.state_q), 32'(SHIFT_DR));
        scan(32, 32'h0, d);
        chk("idcode", d, 32'h1A2B_3C4D);
        walk(1'b1); walk(1'b0);
        chk("rti_after_dr", 32'(dut.u_fsm.state_q), 32'(RTI));

        // USER register write then read-back
        ir_scan(4'b1000, d);
        chk("ir_capture_user", d, 32'h1);
        chk("ir_user", 32'(dut.ir_q), 32'h8);
        dr_scan(8, 32'hA5, d);
        chk("user_first_out", d, 32'h00);
        chk("user_a5", 32'(user_q), 32'hA5);
        dr_scan(8, 32'h3C, d);
        chk("user_readback", d, 32'hA5);
        chk("user_3c", 32'(user_q), 32'h3C);

        // BYPASS: capture 0001 seen during SHIFT_IR, then 1-cycle delay
        ir_scan(4'b1111, d);
        chk("ir_capture_bypass", d, 32'h1);
        chk("ir_bypass", 32'(dut.ir_q), 32'hF);
        dr_scan(4, 32'b1101, d);
        chk("bypass_delay", d, 32'b1010);
        chk("user_kept_bypass", 32'(user_q), 32'h3C);

        // Unused code acts as BYPASS
        ir_scan(4'b0110, d);
        chk("ir_unused", 32'(dut.ir_q), 32'h6);
        dr_scan(4, 32'b1111, d);
        chk("unused_bypass", d, 32'b1110);

        // Load FF so the pass through UPD_DR on the way to TLR rewrites the same value
        ir_scan(4'b1000, d);
        dr_scan(8, 32'hFF, d);
        chk("user_readback2", d, 32'h3C);
        chk("user_ff", 32'(user_q), 32'hFF);
        walk(1'b1); walk(1'b0); walk(1'b0);
        chk("shift_dr_user", 32'(dut.u_fsm.state_q), 32'(SHIFT_DR));
        for (int i = 0; i < 5; i++) begin
            logic o;
            step(1'b1, 1'b1, o);
        end
        chk("tms5_state", 32'(dut.u_fsm.state_q), 32'(TLR));
        chk("tms5_ir", 32'(dut.ir_q), 32'h1);
        chk("tms5_user", 32'(user_q), 32'hFF);

        // Asynchronous reset in the middle of an IDCODE shift
        walk(1'b0); walk(1'b1); walk(1'b0); walk(1'b0);
        walk(1'b0);
        @(negedge tck);
        #2;
        chk("pre_rst_tdo", 32'(tdo), 32'h0);
        chk("pre_rst_state", 32'(dut.u_fsm.state_q), 32'(SHIFT_DR));
        #3;
        trst = 1'b0;
        #1;
        chk("rst_state", 32'(dut.u_fsm.state_q), 32'(TLR));
        chk("rst_ir", 32'(dut.ir_q), 32'h1);
        chk("rst_tdo", 32'(tdo), 32'h0);
        chk("rst_user", 32'(user_q), 32'h0);
        @(negedge tck);
        trst = 1'b1;

        walk(1'b0); walk(1'b1); walk(1'b0); walk(1'b0);
        scan(32, 32'h0, d);
        chk("idcode_after_rst", d, 32'h1A2B_3C4D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
